// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encoding, ARB_MODE
// encodings and the LC-3b word/mask types used at the 16-bit default.
package mem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_RR    = 0;  // round-robin
  localparam int ARB_FIXED = 1;  // fixed priority, port 0 highest

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

endpackage

// File: rtl/rr_select.sv
// Combinational grant selection.
//   req_i        : per-port active request vector
//   last_grant_i : index of the most recently completed grant
//   mode_i       : 0 = round-robin from last_grant_i+1, 1 = lowest index wins
//   winner_o     : selected port index (0 when valid_o is low)
//   valid_o      : at least one port is requesting
module rr_select
  import mem_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_grant_i,
  input  logic                 mode_i,
  output logic [IDX_W-1:0]     winner_o,
  output logic                 valid_o
);

  logic [IDX_W-1:0] idx;

  // Walk the ports in search order and keep the first active one.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (mode_i == 1'(ARB_FIXED)) idx = IDX_W'(i);
      else                         idx = IDX_W'((int'(last_grant_i) + 1 + i) % NUM_PORTS);
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-port to single-memory arbiter. One transaction is in flight at a time:
// a winner is picked in IDLE, its command is latched and held on the memory
// side through BUSY until mem_resp, which is forwarded combinationally as a
// one-cycle req_resp pulse to the granted port.
//   clk, reset               : clock, synchronous active-high reset
//   req_read/req_write       : per-port command requests
//   req_address/wdata/byte_enable : per-port command payload
//   req_resp, req_rdata      : per-port completion pulse, shared read data
//   mem_read/mem_write/mem_address/mem_wdata/mem_byte_enable : memory command
//   mem_resp, mem_rdata      : memory completion and read data
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS  = 2,
  parameter  int ADDR_WIDTH = 16,
  parameter  int DATA_WIDTH = 16,
  parameter  int ARB_MODE   = ARB_RR,
  localparam int BE_W       = DATA_WIDTH / 8,
  localparam int IDX_W      = $clog2(NUM_PORTS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 req_read,
  input  logic [NUM_PORTS-1:0]                 req_write,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_PORTS-1:0][BE_W-1:0]       req_byte_enable,
  output logic [NUM_PORTS-1:0]                 req_resp,
  output logic [DATA_WIDTH-1:0]                req_rdata,
  output logic                                 mem_read,
  output logic                                 mem_write,
  output logic [ADDR_WIDTH-1:0]                mem_address,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  output logic [BE_W-1:0]                      mem_byte_enable,
  input  logic                                 mem_resp,
  input  logic [DATA_WIDTH-1:0]                mem_rdata
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q,  last_d;
  logic             cmd_rd_q, cmd_rd_d;
  logic             cmd_wr_q, cmd_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q,    be_d;

  logic [IDX_W-1:0] sel_winner;
  logic             sel_valid;

  rr_select #(.NUM_PORTS(NUM_PORTS)) u_sel (
    .req_i        (req_read | req_write),
    .last_grant_i (last_q),
    .mode_i       (ARB_MODE == ARB_FIXED),
    .winner_o     (sel_winner),
    .valid_o      (sel_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      last_q   <= IDX_W'(NUM_PORTS - 1);  // port 0 wins first
      cmd_rd_q <= 1'b0;
      cmd_wr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cmd_rd_q <= cmd_rd_d;
      cmd_wr_q <= cmd_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cmd_rd_d  = cmd_rd_q;
    cmd_wr_d  = cmd_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    req_resp  = '0;
    req_rdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          state_d  = ST_BUSY;
          grant_d  = sel_winner;
          // Simultaneous read+write resolves to a read.
          cmd_rd_d = req_read[sel_winner];
          cmd_wr_d = req_write[sel_winner] & ~req_read[sel_winner];
          addr_d   = req_address[sel_winner];
          wdata_d  = req_wdata[sel_winner];
          be_d     = req_byte_enable[sel_winner];
        end
      end
      ST_BUSY: begin
        mem_read  = cmd_rd_q;
        mem_write = cmd_wr_q;
        if (mem_resp) begin
          req_resp[grant_q] = 1'b1;
          req_rdata         = mem_rdata;
          state_d           = ST_IDLE;
          last_d            = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Payload always comes from the command registers, so requester changes
  // during BUSY never reach the memory side.
  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_byte_enable = be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    int       port;
    lc3b_word data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 4-port round-robin instance
  logic [3:0]       rd, wr, resp;
  logic [3:0][15:0] addr, wdata;
  logic [3:0][1:0]  be;
  lc3b_word         rdata, m_rdata, m_addr, m_wdata;
  logic             m_rd, m_wr, m_resp;
  lc3b_mem_wmask    m_be;

  // 2-port fixed-priority instance
  logic [1:0]       f_rd, f_wr, f_resp;
  logic [1:0][15:0] f_addr, f_wdata;
  logic [1:0][1:0]  f_be;
  lc3b_word         f_rdata, f_m_rdata, f_m_addr, f_m_wdata;
  logic             f_m_rd, f_m_wr, f_m_resp;
  lc3b_mem_wmask    f_m_be;

  mem_arbiter #(.NUM_PORTS(4), .ARB_MODE(ARB_RR)) u_rr (
    .clk(clk), .reset(reset),
    .req_read(rd), .req_write(wr), .req_address(addr), .req_wdata(wdata),
    .req_byte_enable(be), .req_resp(resp), .req_rdata(rdata),
    .mem_read(m_rd), .mem_write(m_wr), .mem_address(m_addr), .mem_wdata(m_wdata),
    .mem_byte_enable(m_be), .mem_resp(m_resp), .mem_rdata(m_rdata)
  );

  mem_arbiter #(.NUM_PORTS(2), .ARB_MODE(ARB_FIXED)) u_fx (
    .clk(clk), .reset(reset),
    .req_read(f_rd), .req_write(f_wr), .req_address(f_addr), .req_wdata(f_wdata),
    .req_byte_enable(f_be), .req_resp(f_resp), .req_rdata(f_rdata),
    .mem_read(f_m_rd), .mem_write(f_m_wr), .mem_address(f_m_addr), .mem_wdata(f_m_wdata),
    .mem_byte_enable(f_m_be), .mem_resp(f_m_resp), .mem_rdata(f_m_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Entered just after a rising edge with the DUT in IDLE and requests set up.
  // Holds the memory busy for lat cycles, then responds with rdv.
  task automatic rr_txn(input int port, input bit is_wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [1:0] wbe,
                        input logic [15:0] rdv, input int lat, input bit drop);
    exp_t e;
    e.port = port;
    e.data = rdv;
    sb_q.push_back(e);
    @(negedge clk);
    chk("idle_cmd", {m_rd, m_wr}, 0);
    @(posedge clk); #1;
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      chk("busy_rd", m_rd, !is_wr);
      chk("busy_wr", m_wr, is_wr);
      chk("busy_addr", m_addr, a);
      if (is_wr) begin
        chk("busy_wdata", m_wdata, wd);
        chk("busy_be", m_be, wbe);
      end
      chk("busy_noresp", resp, 0);
      chk("busy_rdata0", rdata, 0);
      if (drop && c == 0) begin
        rd[port[1:0]]    = 1'b0;
        wr[port[1:0]]    = 1'b0;
        addr[port[1:0]]  = 16'hDEAD;
        wdata[port[1:0]] = 16'hFFFF;
        be[port[1:0]]    = 2'b10;
      end
      @(posedge clk); #1;
    end
    m_resp  = 1'b1;
    m_rdata = rdv;
    @(negedge clk);
    chk("resp_addr", m_addr, a);
    e = sb_q.pop_front();
    chk("resp_onehot", resp, 4'(1 << e.port));
    chk("resp_rdata", rdata, e.data);
    @(posedge clk); #1;
    m_resp  = 1'b0;
    m_rdata = '0;
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    rd = '0; wr = '0; addr = '0; wdata = '0; be = '0; m_resp = 1'b0; m_rdata = '0;
    f_rd = '0; f_wr = '0; f_addr = '0; f_wdata = '0; f_be = '0; f_m_resp = 1'b0; f_m_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_cmd", {m_rd, m_wr}, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_resp", resp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_fx_cmd", {f_m_rd, f_m_wr}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single read from port 1
    rd[1] = 1'b1; addr[1] = 16'h0040;
    rr_txn(1, 1'b0, 16'h0040, 16'h0, 2'b00, 16'hBEEF, 2, 1'b0);
    rd = '0;
    repeat (2) begin
      @(negedge clk);
      chk("after_single_resp", resp, 0);
      chk("after_single_rd", m_rd, 0);
      @(posedge clk); #1;
    end

    // Round-robin alternation between two continuous requesters
    addr[0] = 16'h0100; addr[1] = 16'h0200; rd = 4'b0011;
    rr_txn(0, 1'b0, 16'h0100, 16'h0, 2'b00, 16'h1111, 1, 1'b0);
    rr_txn(1, 1'b0, 16'h0200, 16'h0, 2'b00, 16'h2222, 1, 1'b0);
    rr_txn(0, 1'b0, 16'h0100, 16'h0, 2'b00, 16'h3333, 1, 1'b0);
    rr_txn(1, 1'b0, 16'h0200, 16'h0, 2'b00, 16'h4444, 1, 1'b0);
    rd = '0;

    // Write whose requester drops (and scribbles its payload) mid-BUSY
    wr[0] = 1'b1; addr[0] = 16'h0010; wdata[0] = 16'h1234; be[0] = 2'b01;
    rr_txn(0, 1'b1, 16'h0010, 16'h1234, 2'b01, 16'h0000, 3, 1'b1);

    // Reset during BUSY: last_grant is 0 here, so without a proper reset the
    // round-robin pointer would favour port 1 next.
    rd = 4'b0010; addr[1] = 16'h0300;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_busy_rd", m_rd, 1);
    chk("pre_rst_busy_addr", m_addr, 16'h0300);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; rd = '0; m_resp = 1'b1; m_rdata = 16'h5555;
    @(negedge clk);
    chk("rst_busy_noresp", resp, 0);
    chk("rst_busy_rdata", rdata, 0);
    chk("rst_busy_cmd", {m_rd, m_wr}, 0);
    chk("rst_busy_addr", m_addr, 0);
    chk("rst_busy_wdata", m_wdata, 0);
    chk("rst_busy_be", m_be, 0);
    @(posedge clk); #1;
    m_resp = 1'b0; m_rdata = '0;
    addr[0] = 16'h0400; rd = 4'b0011;
    rr_txn(0, 1'b0, 16'h0400, 16'h0, 2'b00, 16'h0A0A, 1, 1'b0);
    rd = '0;

    // Read and write together on port 2 resolves to a read
    rd[2] = 1'b1; wr[2] = 1'b1; addr[2] = 16'h0500; wdata[2] = 16'h9999; be[2] = 2'b11;
    rr_txn(2, 1'b0, 16'h0500, 16'h0, 2'b00, 16'h7777, 1, 1'b0);
    rd = '0; wr = '0;

    // Fixed priority: port 0 keeps winning against port 1
    f_addr[0] = 16'hA000; f_addr[1] = 16'hB000; f_rd = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("fx_busy_rd", f_m_rd, 1);
      chk("fx_busy_addr", f_m_addr, 16'hA000);
      @(posedge clk); #1;
      e.port = 0;
      e.data = 16'(16'h0C00 + i);
      sb_q.push_back(e);
      f_m_resp = 1'b1; f_m_rdata = 16'(16'h0C00 + i);
      @(negedge clk);
      e = sb_q.pop_front();
      chk("fx_resp", f_resp, 2'(1 << e.port));
      chk("fx_rdata", f_rdata, e.data);
      @(posedge clk); #1;
      f_m_resp = 1'b0; f_m_rdata = '0;
      @(negedge clk);
      chk("fx_idle_gap", f_m_rd, 0);
    end
    f_rd = '0;

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
